// File: rtl/cntr_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cntr_gate_ctrl
// Description : Gate-window sequencer for the ADPLL edge counter. Clears the
//               counter, enables it for L cycles, settles one cycle, latches
//               the count. Optional wrap detection under CNTR_GATE_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_gate_ctrl #(
    parameter int CW = 4,
    parameter int GW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_cont,
    input  logic [GW-1:0] i_gate_len,
    input  logic [CW-1:0] i_cnt,
    output logic          o_cnt_clr,
    output logic          o_cnt_en,
    output logic          o_busy,
    output logic [CW-1:0] o_result,
    output logic          o_done,
    output logic          o_ovf
);

    localparam logic [GW-1:0] GATE_ONE = {{(GW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_GATE   = 3'd2,
        S_SETTLE = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    state_t        state;
    logic [GW-1:0] gate_len_q;
    logic [GW-1:0] gate_left;
    logic [GW-1:0] gate_len_eff;

    // A zero-length window would never enable the counter; run one cycle instead.
    assign gate_len_eff = (i_gate_len == '0) ? GATE_ONE : i_gate_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            o_cnt_clr  <= 1'b0;
            o_cnt_en   <= 1'b0;
            o_busy     <= 1'b0;
            o_result   <= '0;
            o_done     <= 1'b0;
            gate_len_q <= '0;
            gate_left  <= '0;
        end else begin
            o_cnt_clr <= 1'b0;
            o_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_CLR;
                        o_cnt_clr  <= 1'b1;
                        o_busy     <= 1'b1;
                        gate_len_q <= gate_len_eff;
                    end
                end
                S_CLR: begin
                    state     <= S_GATE;
                    o_cnt_en  <= 1'b1;
                    gate_left <= gate_len_q;
                end
                S_GATE: begin
                    if (gate_left == GATE_ONE) begin
                        state    <= S_SETTLE;
                        o_cnt_en <= 1'b0;
                    end else begin
                        gate_left <= gate_left - GATE_ONE;
                    end
                end
                S_SETTLE: begin
                    // Counter output has caught up with the last enabled edge here.
                    state    <= S_LATCH;
                    o_result <= i_cnt;
                    o_done   <= 1'b1;
                end
                S_LATCH: begin
                    if (i_cont) begin
                        state      <= S_CLR;
                        o_cnt_clr  <= 1'b1;
                        gate_len_q <= gate_len_eff;
                    end else begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    o_cnt_en <= 1'b0;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CNTR_GATE_OVF_EN
    logic [CW-1:0] prev_cnt;
    logic          wrap_flag;
    logic          wrap_now;

    assign wrap_now = (i_cnt < prev_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_cnt  <= '0;
            wrap_flag <= 1'b0;
            o_ovf     <= 1'b0;
        end else begin
            case (state)
                S_CLR: begin
                    prev_cnt  <= '0;
                    wrap_flag <= 1'b0;
                end
                S_GATE, S_SETTLE: begin
                    prev_cnt <= i_cnt;
                    if (wrap_now) begin
                        wrap_flag <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            // A wrap seen on the settle cycle itself must still reach o_ovf.
            if (state == S_SETTLE) begin
                o_ovf <= wrap_flag | wrap_now;
            end
        end
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cntr_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cntr_gate_ctrl
// Description : Directed bench for cntr_gate_ctrl with a behavioural counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cntr_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic [7:0] gate_len;
    logic [3:0] cnt;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic [3:0] result;
    logic       done;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    cntr_gate_ctrl #(.CW(4), .GW(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_cont     (cont),
        .i_gate_len (gate_len),
        .i_cnt      (cnt),
        .o_cnt_clr  (cnt_clr),
        .o_cnt_en   (cnt_en),
        .o_busy     (busy),
        .o_result   (result),
        .o_done     (done),
        .o_ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: sync clear, enable increments with wrap, registered output.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= 4'd0;
        end else if (cnt_en) begin
            cnt <= cnt + 4'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-shot measurement, checked cycle by cycle from the accepting edge.
    task automatic measure(input logic [7:0] len, input int lq, input logic [3:0] exp_res,
                           input logic exp_ovf, input bit disturb);
        gate_len = len;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_pulse", cnt_clr, 1'b1);
        chk("clr_no_en", cnt_en, 1'b0);
        chk("busy_clr", busy, 1'b1);
        for (int i = 1; i <= lq; i++) begin
            if (disturb && i == 2) begin
                start    = 1'b1;
                gate_len = 8'd2;
            end
            tick();
            start = 1'b0;
            chk("gate_en", cnt_en, 1'b1);
            chk("gate_no_clr", cnt_clr, 1'b0);
            chk("gate_no_done", done, 1'b0);
        end
        tick();
        chk("settle_en", cnt_en, 1'b0);
        chk("settle_done", done, 1'b0);
        tick();
        chk("latch_done", done, 1'b1);
        chk("latch_result", result, exp_res);
        chk("latch_ovf", ovf, exp_ovf);
        chk("latch_busy", busy, 1'b1);
        tick();
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_result", result, exp_res);
    endtask

    logic exp_wrap;

    initial begin
`ifdef CNTR_GATE_OVF_EN
        exp_wrap = 1'b1;
`else
        exp_wrap = 1'b0;
`endif
        rst      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        gate_len = 8'd0;

        // Reset for three cycles with a start pulse inside it.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_clr", cnt_clr, 1'b0);
        chk("rst_en", cnt_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        tick();
        tick();
        chk("rst_start_ignored", busy, 1'b0);

        // Basic window, zero length, maximum non-wrapping length.
        measure(8'd4, 4, 4'd4, 1'b0, 1'b0);
        measure(8'd0, 1, 4'd1, 1'b0, 1'b0);
        measure(8'd15, 15, 4'd15, 1'b0, 1'b0);

        // Start and length change during GATE are ignored.
        measure(8'd6, 6, 4'd6, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_second_done", done, 1'b0);
            chk("no_second_busy", busy, 1'b0);
        end

        // Continuous mode: done every 6 cycles, drop cont inside the third window.
        gate_len = 8'd3;
        cont     = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            for (int j = 1; j <= 6; j++) begin
                if (k == 1 && j == 6) break;
                tick();
                if (k == 3 && j == 1) cont = 1'b0;
                if (k > 1 && j == 1) chk("cont_clr", cnt_clr, 1'b1);
                if (j < 6 && !(k == 1 && j == 5)) chk("cont_no_done", done, 1'b0);
            end
            chk("cont_done", done, 1'b1);
            chk("cont_result", result, 4'd3);
        end
        tick();
        chk("cont_stop_busy", busy, 1'b0);
        chk("cont_stop_clr", cnt_clr, 1'b0);
        tick();
        chk("cont_stop_done", done, 1'b0);

        // Wrapping window.
        measure(8'd20, 20, 4'd4, exp_wrap, 1'b0);

        // Reset mid-GATE.
        gate_len = 8'd20;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_en", cnt_en, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_en", cnt_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_result", result, 4'd0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_clr", cnt_clr, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk("after_rst_busy", busy, 1'b0);
        chk("after_rst_done", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
